// File: rtl/spix_pkg.sv
// Shared types and helpers for the spix_rctr SPI master: FSM states,
// datawidth encodings, divider sizing and byte-order mapping.
package spix_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [1:0] DW_8  = 2'b00;
   localparam logic [1:0] DW_16 = 2'b10;
   localparam logic [1:0] DW_32 = 2'b01;

   function automatic int unsigned div_width(input int unsigned max_h);
      return (max_h < 2) ? 1 : $clog2(max_h + 1);
   endfunction

   // Index of the final sclk half period (2N-1) for a datawidth code.
   function automatic logic [5:0] last_half(input logic [1:0] dw);
      case (dw)
         DW_16:   return 6'd31;
         DW_32:   return 6'd63;
         default: return 6'd15;
      endcase
   endfunction

   // Word in the low N bits, reordered so the first byte on the wire is
   // the most significant one; its own inverse, so it serves tx and rx.
   function automatic logic [31:0] order_bytes(input logic [31:0] d,
                                               input logic [1:0] dw,
                                               input logic msb_first);
      case (dw)
         DW_16:   return msb_first ? {16'h0, d[15:0]} : {16'h0, d[7:0], d[15:8]};
         DW_32:   return msb_first ? d : {d[7:0], d[15:8], d[23:16], d[31:24]};
         default: return {24'h0, d[7:0]};
      endcase
   endfunction

   function automatic logic [31:0] tx_stream(input logic [31:0] d,
                                             input logic [1:0] dw,
                                             input logic msb_first);
      logic [31:0] o;
      o = order_bytes(d, dw, msb_first);
      case (dw)
         DW_16:   return {o[15:0], 16'h0};
         DW_32:   return o;
         default: return {o[7:0], 24'h0};
      endcase
   endfunction

endpackage

// File: rtl/spix_clkdiv.sv
// Half-bit tick generator: tick_c pulses every `half` cycles while en=1,
// restarting from zero whenever en drops.
module spix_clkdiv #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] half,
   output logic         tick_c
);

   logic [W-1:0] cnt;

   assign tick_c = en && (cnt == half - W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (!en || tick_c)
         cnt <= '0;
      else
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/spix_rctr.sv
// SPI master with selectable width, byte order, mode and chip-select hold.
// Optional internal loopback port when SPIX_RCTR_LOOPBACK_EN is defined.
module spix_rctr
   import spix_pkg::*;
#(
   parameter  int unsigned CLOCK_FREQ = 50000000,
   parameter  int unsigned FAST_SCLK  = 10000000,
   parameter  int unsigned SLOW_SCLK  = 400000,
   parameter  int unsigned NUM_CS     = 4,
   localparam int unsigned CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              fast,
   input  logic              msbytefirst,
   input  logic [1:0]        datawidth,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [CSW-1:0]    cs_sel,
   input  logic              cs_hold,
   input  logic              miso,
`ifdef SPIX_RCTR_LOOPBACK_EN
   input  logic              loopback,
`endif
   input  logic [31:0]       dataTx,
   output logic [31:0]       dataRx,
   output logic              rdy,
   output logic              mosi,
   output logic              sclk,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int unsigned H_FAST_RAW = CLOCK_FREQ / (2 * FAST_SCLK);
   localparam int unsigned H_SLOW_RAW = CLOCK_FREQ / (2 * SLOW_SCLK);
   localparam int unsigned H_FAST     = (H_FAST_RAW == 0) ? 1 : H_FAST_RAW;
   localparam int unsigned H_SLOW     = (H_SLOW_RAW == 0) ? 1 : H_SLOW_RAW;
   localparam int unsigned H_MAX      = (H_FAST > H_SLOW) ? H_FAST : H_SLOW;
   localparam int unsigned DVW        = div_width(H_MAX);

   state_t          state;
   logic [32:0]     sr;
   logic [31:0]     rx_sh;
   logic [5:0]      half_cnt;
   logic            fast_l, msb_l, cpol_l, cpha_l, hold_l, lb_l;
   logic [1:0]      dw_l;
   logic            tick_c, busy_c, rx_bit_c, lb_in_c;
   logic [DVW-1:0]  half_c;
   logic [NUM_CS-1:0] cs_dec_c;

`ifdef SPIX_RCTR_LOOPBACK_EN
   assign lb_in_c = loopback;
`else
   assign lb_in_c = 1'b0;
`endif

   assign busy_c   = (state != ST_IDLE);
   assign half_c   = fast_l ? DVW'(H_FAST) : DVW'(H_SLOW);
   assign rx_bit_c = lb_l ? sr[32] : miso;
   // sr[32] is the bit on the wire; idle and reset fill it with ones.
   assign mosi     = sr[32];

   always_comb begin
      cs_dec_c = '1;
      for (int i = 0; i < int'(NUM_CS); i++)
         if (CSW'(i) == cs_sel) cs_dec_c[i] = 1'b0;
   end

   spix_clkdiv #(.W(DVW)) u_clkdiv (
      .clk    (clk),
      .rst    (rst),
      .en     (busy_c),
      .half   (half_c),
      .tick_c (tick_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         rdy      <= 1'b1;
         cs_n     <= '1;
         sclk     <= 1'b0;
         sr       <= '1;
         rx_sh    <= '0;
         dataRx   <= '0;
         half_cnt <= '0;
         fast_l   <= 1'b0;
         msb_l    <= 1'b0;
         dw_l     <= DW_8;
         cpol_l   <= 1'b0;
         cpha_l   <= 1'b0;
         hold_l   <= 1'b0;
         lb_l     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               fast_l   <= fast;
               msb_l    <= msbytefirst;
               dw_l     <= datawidth;
               cpol_l   <= cpol;
               cpha_l   <= cpha;
               hold_l   <= cs_hold;
               lb_l     <= lb_in_c;
               // cpha=1 keeps mosi idle through SETUP; first bit appears on the leading edge
               sr       <= cpha ? {1'b1, tx_stream(dataTx, datawidth, msbytefirst)}
                                : {tx_stream(dataTx, datawidth, msbytefirst), 1'b1};
               rx_sh    <= '0;
               half_cnt <= '0;
               cs_n     <= lb_in_c ? '1 : cs_dec_c;
               sclk     <= cpol;
               rdy      <= 1'b0;
               state    <= ST_SETUP;
            end
            ST_SETUP: if (tick_c) state <= ST_XFER;
            ST_XFER: if (tick_c) begin
               half_cnt <= half_cnt + 6'd1;
               if (!half_cnt[0]) begin
                  sclk <= ~cpol_l;
                  if (cpha_l) sr    <= {sr[31:0], 1'b1};
                  else        rx_sh <= {rx_sh[30:0], rx_bit_c};
               end else begin
                  sclk <= cpol_l;
                  if (cpha_l) rx_sh <= {rx_sh[30:0], rx_bit_c};
                  else        sr    <= {sr[31:0], 1'b1};
               end
               if (half_cnt == last_half(dw_l)) state <= ST_HOLD;
            end
            ST_HOLD: if (tick_c) begin
               state  <= ST_IDLE;
               rdy    <= 1'b1;
               dataRx <= order_bytes(rx_sh, dw_l, msb_l);
               sr     <= '1;
               if (!hold_l) cs_n <= '1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
